// File: rtl/lab2_display_scan_if.sv
// Bundle between the lab2 logic circuit and its seven-segment display stage.
//   A..D  : circuit input nibble, A is the MSB
//   K..N  : circuit output nibble, K is the MSB
//   hold  : 1 freezes the values currently shown
//   seg   : active-low cathodes, seg[0]=a .. seg[6]=g
//   dp    : active-low decimal point
//   an    : active-low anodes, an[0] is the rightmost digit
// master drives the data and hold; slave is the display stage.
interface lab2_display_scan_if;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic       K;
  logic       L;
  logic       M;
  logic       N;
  logic       hold;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output A, B, C, D, K, L, M, N, hold,
    input  seg, dp, an
  );

  modport slave (
    input  A, B, C, D, K, L, M, N, hold,
    output seg, dp, an
  );
endinterface

// File: rtl/lab2_display_scan.sv
// Display stage for the lab2 4-in/4-out circuit on the Basys3 4-digit
// seven-segment display. Shows the output nibble {K,L,M,N} on the rightmost
// digit and the input nibble {A,B,C,D} two digits left of it, with that
// digit's decimal point lit as a separator. Digits are scanned one slot of
// REFRESH_DIV clocks each; both nibbles are sampled only at the frame
// boundary so a frame always shows one consistent pair.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : slave side of lab2_display_scan_if (data in, seg/dp/an out)
module lab2_display_scan #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               reset,
  lab2_display_scan_if.slave bus
);

  localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0] prescaler;
  logic          tick;
  logic [1:0]    digit_idx;
  logic [3:0]    in_snap;
  logic [3:0]    out_snap;
  logic [3:0]    hex_val;
  logic [6:0]    hex_seg;

  assign tick = (prescaler == PW'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      digit_idx <= '0;
      in_snap   <= '0;
      out_snap  <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        digit_idx <= digit_idx + 2'd1;
      end
      // Frame boundary: last tick of slot 3. hold wins over capture.
      if (tick && (digit_idx == 2'd3) && !bus.hold) begin
        in_snap  <= {bus.A, bus.B, bus.C, bus.D};
        out_snap <= {bus.K, bus.L, bus.M, bus.N};
      end
    end
  end

  // Only slots 0 and 2 show a value; the mux picks which snapshot to decode.
  assign hex_val = digit_idx[1] ? in_snap : out_snap;

  always_comb begin
    hex_seg = 7'h7F;
    case (hex_val)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      4'hF: hex_seg = 7'h0E;
      default: hex_seg = 7'h7F;
    endcase
  end

  always_comb begin
    bus.an  = 4'b1110;
    bus.seg = 7'h7F;
    bus.dp  = 1'b1;
    case (digit_idx)
      2'd0: begin
        bus.an  = 4'b1110;
        bus.seg = hex_seg;
      end
      2'd1: begin
        bus.an  = 4'b1101;
      end
      2'd2: begin
        bus.an  = 4'b1011;
        bus.seg = hex_seg;
        bus.dp  = 1'b0;
      end
      2'd3: begin
        bus.an  = 4'b0111;
      end
      default: begin
        bus.an  = 4'b1110;
      end
    endcase
  end

endmodule

// File: tb/tb_lab2_display_scan.sv
// Self-checking bench for lab2_display_scan with REFRESH_DIV=4 (16-cycle frame).
// Reference model: counts non-reset edges since reset; slot = (n/4)%4; a
// capture happens on the edge taken while n%16==15 unless hold is high.
module tb_lab2_display_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lab2_display_scan_if bus ();

  lab2_display_scan #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int unsigned n;
  logic [3:0]  m_in;
  logic [3:0]  m_out;
  int unsigned passed;
  int unsigned total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h (model n=%0d)", tag, obs, exp, n);
  endtask

  task automatic drive(input logic [3:0] vin, input logic [3:0] vout, input logic h);
    {bus.A, bus.B, bus.C, bus.D} = vin;
    {bus.K, bus.L, bus.M, bus.N} = vout;
    bus.hold = h;
  endtask

  // One clock: update the model from the inputs present at the edge, then
  // compare every output on the falling edge.
  task automatic step();
    logic [1:0] slot;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    @(posedge clk);
    if (rst) begin
      n = 0; m_in = '0; m_out = '0;
    end else begin
      if ((n % 16) == 15 && !bus.hold) begin
        m_in  = {bus.A, bus.B, bus.C, bus.D};
        m_out = {bus.K, bus.L, bus.M, bus.N};
      end
      n++;
    end
    @(negedge clk);
    slot = 2'((n / 4) % 4);
    case (slot)
      2'd0: begin e_an = 4'b1110; e_seg = hex_tab[m_out]; e_dp = 1'b1; end
      2'd1: begin e_an = 4'b1101; e_seg = 7'h7F;          e_dp = 1'b1; end
      2'd2: begin e_an = 4'b1011; e_seg = hex_tab[m_in];  e_dp = 1'b0; end
      default: begin e_an = 4'b0111; e_seg = 7'h7F;       e_dp = 1'b1; end
    endcase
    check("an", 32'(bus.an), 32'(e_an));
    check("seg", 32'(bus.seg), 32'(e_seg));
    check("dp", 32'(bus.dp), 32'(e_dp));
    check("an_onehot_low", 32'($countones(~bus.an)), 32'd1);
  endtask

  task automatic steps(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) step();
  endtask

  // Advance until the next edge is a frame boundary (bounded to one frame).
  task automatic align();
    for (int unsigned i = 0; i < 16 && (n % 16) != 15; i++) step();
  endtask

  initial begin
    logic [3:0] a, b, held_in, held_out;
    n = 0; m_in = '0; m_out = '0; passed = 0; total = 0;

    // 1. Reset with random inputs
    drive(4'($urandom), 4'($urandom), 1'($urandom));
    steps(3);
    check("rst_an", 32'(bus.an), 32'h0000000E);
    check("rst_seg", 32'(bus.seg), 32'h00000040);
    check("rst_dp", 32'(bus.dp), 32'd1);
    rst = 1'b0;
    drive(4'($urandom), 4'($urandom), 1'b0);
    steps(3);
    check("post_rst_an4", 32'(bus.an), 32'h0000000E);
    step();
    check("post_rst_an5", 32'(bus.an), 32'h0000000D);

    // 2. Free run with random inputs and hold, changed every cycle
    for (int unsigned i = 0; i < 40; i++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom));
      step();
    end

    // 3. Capture at a boundary, then a mid-frame change shows a frame later
    align();
    drive(4'b0110, 4'b1011, 1'b0);
    step();
    check("cap_idx0_b", 32'(bus.seg), 32'h00000003);
    steps(8);
    check("cap_idx2_6", 32'(bus.seg), 32'h00000002);
    check("cap_idx2_dp", 32'(bus.dp), 32'd0);
    a = 4'($urandom); b = 4'($urandom);
    drive(a, b, 1'b0);
    steps(7);
    step();
    check("mid_new_idx0", 32'(bus.seg), 32'(hex_tab[b]));
    steps(8);
    check("mid_new_idx2", 32'(bus.seg), 32'(hex_tab[a]));

    // 4. Hold freezes the display while inputs sweep all codes
    align();
    held_in = 4'b0011; held_out = 4'($urandom);
    drive(held_in, held_out, 1'b0);
    step();
    for (int unsigned i = 0; i < 48; i++) begin
      drive(4'(i), 4'(15 - (i % 16)), 1'b1);
      step();
    end
    align();
    steps(1);
    check("hold_idx0", 32'(bus.seg), 32'(hex_tab[held_out]));
    steps(8);
    check("hold_idx2", 32'(bus.seg), 32'(hex_tab[held_in]));
    a = 4'($urandom); b = 4'($urandom);
    drive(a, b, 1'b0);
    align();
    step();
    check("unhold_idx0", 32'(bus.seg), 32'(hex_tab[b]));
    steps(8);
    check("unhold_idx2", 32'(bus.seg), 32'(hex_tab[a]));

    // 5. Exhaustive decode on both digits
    align();
    for (int unsigned v = 0; v < 16; v++) begin
      drive(4'(v), 4'(15 - v), 1'b0);
      step();
      check("dec_out", 32'(bus.seg), 32'(hex_tab[15 - v]));
      steps(8);
      check("dec_in", 32'(bus.seg), 32'(hex_tab[v]));
      steps(7);
    end

    // 6. Reset in slot 2 with non-zero snapshots
    drive(4'h5, 4'h9, 1'b0);
    steps(9);
    check("pre_rst_slot2", 32'(bus.an), 32'h0000000B);
    rst = 1'b1;
    step();
    check("midrst_an", 32'(bus.an), 32'h0000000E);
    check("midrst_seg", 32'(bus.seg), 32'h00000040);
    rst = 1'b0;
    drive(4'h0, 4'h0, 1'b0);
    steps(16);
    check("midrst_out0", 32'(bus.seg), 32'h00000040);
    steps(8);
    check("midrst_in0", 32'(bus.seg), 32'h00000040);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lab2_display_scan.md
Name: lab2_display_scan

Overview:
- Downstream display stage for the lab2 4-in/4-out logic circuit.
- Captures the circuit's input nibble {A,B,C,D} and output nibble {K,L,M,N} and shows both as hex digits on the Basys3 4-digit seven-segment display.
- Time-multiplexes the digits with a prescaled refresh scan.
- Captures data only at frame boundaries, so all digits within one frame are mutually consistent.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 ms at 100 MHz); legal range >= 2.

Ports:
clk  input  1  system clock; sole clock domain.
reset  input  1  synchronous, active-high reset.
A  input  1  circuit input, MSB of input nibble.
B  input  1  circuit input.
C  input  1  circuit input.
D  input  1  circuit input, LSB.
K  input  1  circuit output, MSB of output nibble.
L  input  1  circuit output.
M  input  1  circuit output.
N  input  1  circuit output, LSB.
hold  input  1  1 = freeze the displayed values.
seg  output  7  cathodes, active-low; seg[0]=a .. seg[6]=g.
dp  output  1  decimal point, active-low.
an  output  4  anodes, active-low; an[0] = rightmost digit.

Behaviour:
Clock and reset:
- Single clock (clk); reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset asserted at any edge, including mid-frame, forces on that edge: prescaler=0, digit_idx=0, in_snap=0, out_snap=0.
- Reset output values: an=4'b1110, seg=7'b1000000 (hex 0), dp=1.

Prescaler:
- Counts 0..REFRESH_DIV-1 and wraps.
- tick=1 for exactly one cycle, when the count equals REFRESH_DIV-1.

Digit scan:
- digit_idx is 2 bits and advances on tick: 0->1->2->3->0.
- Slot length is REFRESH_DIV cycles; frame length is 4*REFRESH_DIV cycles.

Snapshot:
- On the edge where tick=1 and digit_idx=3 (frame boundary, idx wraps to 0): in_snap<={A,B,C,D} and out_snap<={K,L,M,N}, unless hold=1.
- hold=1 at a boundary: snapshots keep their previous values. Hold takes priority over capture.
- Input changes at any other time have no effect until the next boundary.

Output decode:
- Purely from registers (digit_idx, in_snap, out_snap). No combinational path from A..N or hold to any output.
- idx0: an=1110, seg=hex(out_snap), dp=1.
- idx1: an=1101, seg=7'b1111111 (blank), dp=1.
- idx2: an=1011, seg=hex(in_snap), dp=0 (separator).
- idx3: an=0111, seg=7'b1111111, dp=1.
- Exactly one anode is low at all times.

Hex code (seg[6:0]):
0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.

Latency:
- A value present on the inputs at a frame-boundary edge appears on seg during the very next idx0 slot, starting the cycle after that edge.
- A change made just after a boundary appears up to 4*REFRESH_DIV+1 cycles later.

Test Plan:
All runs use REFRESH_DIV=4, so a frame is 16 cycles.
1. Reset: hold reset 3 cycles with random inputs -> an=1110, seg=40, dp=1; first 4 cycles after release keep an=1110; an=1101 from cycle 5.
2. Scan: free-run 40 cycles -> an sequence 1110,1101,1011,0111 repeating, each value held 4 cycles; dp=0 only while an=1011; one-hot-low anode checked every cycle.
3. Capture: apply ABCD=0110 and KLMN=1011 before a frame boundary -> next frame shows idx0 seg=03 (b) and idx2 seg=02 (6). Change the inputs mid-frame -> the current frame is unchanged; the new values appear the following frame.
4. Hold: hold=1 with ABCD=0011, then sweep the inputs through all 16 codes over 3 frames -> displayed values frozen. Release hold -> the latest inputs appear after the next boundary.
5. Exhaustive decode: step ABCD and KLMN through 0000..1111, one value per frame -> seg matches the hex table for every code on both digits.
6. Reset mid-frame: assert reset while digit_idx=2 with snapshots non-zero -> the next edge gives an=1110, seg=40, and the snapshots read 0 in the next frame if inputs are 0.
